serializer: RTL

- Parallel-to-serial converter; the transmit end of the bit-serial path whose receive end shifts bits into LSB position.
- Loads a LENGTH-bit word and emits it MSB first, one bit per accepted cycle.
- A receiver that shifts each valid bit in at the LSB therefore rebuilds the original word after LENGTH accepted bits.
- Sits between the P02 datapath result register and any serial consumer. Has a start/ready load handshake and a valid/enable stall handshake.

---
 rtl/serializer_pkg.sv | 16 +
 rtl/serializer_if.sv | 25 ++
 rtl/serializer_bit_counter.sv | 35 +++
 rtl/serializer_shifter.sv | 13 +
 rtl/serializer.sv | 84 ++++++++
 5 files changed

// File: rtl/serializer_pkg.sv
// Shared width constants, bus type and FSM state encoding for the serializer.
// Imported by the interface, the sub-modules and the top.
package serializer_pkg;

  localparam int LENGTH = 16;
  localparam int CNT_W  = $clog2(LENGTH);

  typedef logic [LENGTH-1:0] buses;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } ser_state_e;

endpackage

// File: rtl/serializer_if.sv
// Load (start/ready) and serial (valid/shift_en) handshake bundle of the serializer.
// The slave modport is the serializer itself; the master is its producer/consumer.
interface serializer_if;
  import serializer_pkg::*;

  logic start;
  buses ins;
  logic shift_en;
  logic ready;
  logic bout;
  logic bout_valid;
  logic last;
  logic done;

  modport master (
    output start, ins, shift_en,
    input  ready, bout, bout_valid, last, done
  );

  modport slave (
    input  start, ins, shift_en,
    output ready, bout, bout_valid, last, done
  );

endinterface

// File: rtl/serializer_bit_counter.sv
// Bit position counter with clear, enable and terminal count at LENGTH-1.
// Saturates at the terminal value so it can never wrap inside a word.
module serializer_bit_counter
  import serializer_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == CNT_W'(LENGTH - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serializer_shifter.sv
// LSB-insert shifter: moves the word one place towards the MSB and inserts bin_i at bit 0.
// Purely combinational.
module serializer_shifter
  import serializer_pkg::*;
(
  input  buses dout_src_i,
  input  logic bin_i,
  output buses dout_o
);

  assign dout_o = (dout_src_i << 1) | buses'(bin_i);

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial converter: loads a LENGTH-bit word on start&ready and emits it MSB first,
// one bit per cycle with shift_en high, followed by a one-cycle done pulse.
module serializer
  import serializer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  serializer_if.slave  bus
);

  ser_state_e state_q;
  ser_state_e state_d;
  buses       shift_q;
  buses       shift_d;
  buses       shifted;
  logic       load;
  logic       advance;
  logic       tc;

  assign load    = (state_q == IDLE) && bus.start;
  assign advance = (state_q == SHIFT) && bus.shift_en;

  serializer_shifter u_shifter (
    .dout_src_i (shift_q),
    .bin_i      (1'b0),
    .dout_o     (shifted)
  );

  serializer_bit_counter u_bit_counter (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (load),
    .en_i  (advance),
    .tc_o  (tc)
  );

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bus.ready      = 1'b0;
    bus.bout_valid = 1'b0;
    bus.last       = 1'b0;
    bus.done       = 1'b0;
    bus.bout       = shift_q[LENGTH-1];
    unique case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          shift_d = bus.ins;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bus.bout_valid = 1'b1;
        bus.last       = tc;
        if (bus.shift_en) begin
          shift_d = shifted;
          if (tc) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        // After LENGTH zero-filling shifts the register is already clear, so bout reads 0 here.
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

endmodule
